// File: rtl/regfile_wb_sched_if.sv
// Bundle between decode/issue, the ALU/LSU writeback sources and the register file write port.
// master = issue + execution side, slave = regfile_wb_sched.
interface regfile_wb_sched_if #(
    parameter int WIDTH     = 32,
    parameter int REG_COUNT = 32,
    parameter int REG_BITS  = $clog2(REG_COUNT)
);
    logic                 issue_valid;
    logic [REG_BITS-1:0]  issue_rs1;
    logic                 issue_rs1_en;
    logic [REG_BITS-1:0]  issue_rs2;
    logic                 issue_rs2_en;
    logic [REG_BITS-1:0]  issue_rd;
    logic                 issue_rd_en;
    logic                 issue_stall;

    logic                 alu_wb_valid;
    logic [REG_BITS-1:0]  alu_wb_rd;
    logic [WIDTH-1:0]     alu_wb_data;
    logic                 alu_wb_ready;

    logic                 lsu_wb_valid;
    logic [REG_BITS-1:0]  lsu_wb_rd;
    logic [WIDTH-1:0]     lsu_wb_data;
    logic                 lsu_wb_ready;

    logic                 rf_write_en;
    logic [REG_BITS-1:0]  rf_write_reg;
    logic [WIDTH-1:0]     rf_write_data;
    logic [REG_COUNT-1:0] busy_mask;

    modport master (
        output issue_valid, issue_rs1, issue_rs1_en, issue_rs2, issue_rs2_en, issue_rd, issue_rd_en,
        output alu_wb_valid, alu_wb_rd, alu_wb_data, lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        input  issue_stall, alu_wb_ready, lsu_wb_ready,
        input  rf_write_en, rf_write_reg, rf_write_data, busy_mask
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs1_en, issue_rs2, issue_rs2_en, issue_rd, issue_rd_en,
        input  alu_wb_valid, alu_wb_rd, alu_wb_data, lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        output issue_stall, alu_wb_ready, lsu_wb_ready,
        output rf_write_en, rf_write_reg, rf_write_data, busy_mask
    );
endinterface

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler + scoreboard: round-robin ALU/LSU onto one regfile write port, RAW/WAW stall.
// Optional WB_ERR_EN: sticky wb_err on a writeback to a register that was not pending.
module regfile_wb_sched #(
    parameter int WIDTH     = 32,
    parameter int REG_COUNT = 32,
    parameter int REG_BITS  = $clog2(REG_COUNT)
) (
    input  logic                clk,
    input  logic                rstn,
    regfile_wb_sched_if.slave   bus
`ifdef WB_ERR_EN
    ,
    output logic                wb_err
`endif
);

    logic [REG_COUNT-1:0] busy_q, busy_d;
    logic                 rr_q, rr_d;
    logic                 we_q, we_d;
    logic [REG_BITS-1:0]  wreg_q, wreg_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d;

    logic                 gnt_alu, gnt_lsu, gnt_any, accept;
    logic [REG_BITS-1:0]  gnt_rd;
    logic [WIDTH-1:0]     gnt_data;

    always_comb begin
        bus.issue_stall = bus.issue_valid &&
                          ((bus.issue_rs1_en && busy_q[bus.issue_rs1]) ||
                           (bus.issue_rs2_en && busy_q[bus.issue_rs2]) ||
                           (bus.issue_rd_en  && busy_q[bus.issue_rd]));
        accept = bus.issue_valid && !bus.issue_stall && bus.issue_rd_en && (bus.issue_rd != '0);
    end

    // Grants are held off while in reset so nothing handshakes into a discarded pipeline.
    always_comb begin
        gnt_alu  = rstn && bus.alu_wb_valid && (!bus.lsu_wb_valid || !rr_q);
        gnt_lsu  = rstn && bus.lsu_wb_valid && (!bus.alu_wb_valid ||  rr_q);
        gnt_any  = gnt_alu || gnt_lsu;
        gnt_rd   = gnt_lsu ? bus.lsu_wb_rd   : bus.alu_wb_rd;
        gnt_data = gnt_lsu ? bus.lsu_wb_data : bus.alu_wb_data;

        rr_d = rr_q;
        if (gnt_alu)      rr_d = 1'b1;
        else if (gnt_lsu) rr_d = 1'b0;

        we_d    = gnt_any && (gnt_rd != '0);
        wreg_d  = gnt_any ? gnt_rd   : wreg_q;
        wdata_d = gnt_any ? gnt_data : wdata_q;

        // Clear before set so a same-edge set wins.
        busy_d = busy_q;
        if (we_q)   busy_d[wreg_q]       = 1'b0;
        if (accept) busy_d[bus.issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q  <= '0;
            rr_q    <= 1'b0;
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            busy_q  <= busy_d;
            rr_q    <= rr_d;
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.alu_wb_ready  = gnt_alu;
    assign bus.lsu_wb_ready  = gnt_lsu;
    assign bus.rf_write_en   = we_q;
    assign bus.rf_write_reg  = wreg_q;
    assign bus.rf_write_data = wdata_q;
    assign bus.busy_mask     = busy_q;

`ifdef WB_ERR_EN
    logic err_q, err_d;

    always_comb err_d = err_q || (gnt_any && (gnt_rd != '0) && !busy_q[gnt_rd]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign wb_err = err_q;
`endif

endmodule
